// File: rtl/sr_register_write_arbiter_pkg.sv
// Shared definitions for the SR-register write arbiter: FSM encoding,
// default register width and a helper for index widths.
package sr_ctrl_pkg;

  localparam int unsigned W_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_register_write_arbiter_if.sv
// Requester/register bus of the SR-register write arbiter.
// master: requester side plus the register readback; slave: the arbiter.
interface sr_register_write_arbiter_if
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = W_DEFAULT
);

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   q;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   s;
  logic [W-1:0]   r;
  logic           busy;
  logic           err;

  modport master (
    output req, wdata, q,
    input  gnt, done, s, r, busy, err
  );

  modport slave (
    input  req, wdata, q,
    output gnt, done, s, r, busy, err
  );

endinterface

// File: rtl/sr_register_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c
);

  logic [N-1:0] upper;
  logic [N-1:0] pick;

  // Prefer requesters at/after the pointer; otherwise wrap to the lowest index.
  always_comb begin
    upper = '0;
    for (int unsigned b = 0; b < N; b++) begin
      upper[b] = req[b] && (IW'(b) >= ptr);
    end
    pick  = (|upper) ? upper : req;
    gnt_c = '0;
    idx_c = '0;
    for (int b = int'(N) - 1; b >= 0; b--) begin
      if (pick[b]) begin
        gnt_c    = '0;
        gnt_c[b] = 1'b1;
        idx_c    = IW'(b);
      end
    end
  end

endmodule

// File: rtl/sr_register_write_arbiter.sv
// Round-robin write arbiter for a shared SR-flip-flop register.
// Each write: latch data, drive s/r for one cycle, wait for the register,
// then pulse done. s and r are never both high.
// Each registered output reflects the FSM phase of the previous cycle, so
// s/r appear one edge after the grant and done/err three edges after it.
// Optional macro READBACK_VERIFY_EN: compare readback q with the written
// byte and flag err together with done.
module sr_register_write_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = W_DEFAULT
) (
  input logic                        clk,
  input logic                        rst_n,
  sr_register_write_arbiter_if.slave bus
);

  localparam int unsigned IW = idx_width(N);

  logic [1:0]    st,     st_nxt;
  logic [IW-1:0] ptr,    ptr_nxt;
  logic [IW-1:0] idx,    idx_nxt;
  logic [W-1:0]  dlat,   dlat_nxt;
  logic [N-1:0]  gnt_q,  gnt_nxt;
  logic [N-1:0]  done_q, done_nxt;
  logic [W-1:0]  s_q,    s_nxt;
  logic [W-1:0]  r_q,    r_nxt;
  logic          busy_q, busy_nxt;
  logic          err_q,  err_nxt;

  logic [N-1:0]  arb_gnt_c;
  logic [IW-1:0] arb_idx_c;
  logic [W-1:0]  lane_c;

  rr_arbiter #(.N(N), .IW(IW)) u_rr_arbiter (
    .req   (bus.req),
    .ptr   (ptr),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c)
  );

  // Data lane of the requester the arbiter would grant this cycle.
  always_comb begin
    lane_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (arb_idx_c == IW'(k)) lane_c = bus.wdata[k*W +: W];
    end
  end

`ifndef READBACK_VERIFY_EN
  logic unused_q_c;
  assign unused_q_c = ^bus.q;
`endif

  // Next-state and next-output decode.
  always_comb begin
    st_nxt   = st;
    ptr_nxt  = ptr;
    idx_nxt  = idx;
    dlat_nxt = dlat;
    gnt_nxt  = gnt_q;
    done_nxt = '0;
    s_nxt    = '0;
    r_nxt    = '0;
    err_nxt  = 1'b0;
    case (st)
      ST_IDLE: begin
        if (|bus.req) begin
          idx_nxt  = arb_idx_c;
          gnt_nxt  = arb_gnt_c;
          dlat_nxt = lane_c;
          st_nxt   = ST_DRIVE;
        end else begin
          gnt_nxt = '0;
        end
      end
      ST_DRIVE: begin
        s_nxt  = dlat;
        r_nxt  = ~dlat;
        st_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        st_nxt = ST_ACK;
      end
      ST_ACK: begin
        done_nxt = gnt_q;
`ifdef READBACK_VERIFY_EN
        // Case inequality so an undefined readback also flags an error.
        err_nxt  = (bus.q !== dlat);
`endif
        ptr_nxt  = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        st_nxt   = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
    busy_nxt = (st_nxt != ST_IDLE);
  end

  // State, pointer, latched data and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      ptr    <= '0;
      idx    <= '0;
      dlat   <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      s_q    <= '0;
      r_q    <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st     <= st_nxt;
      ptr    <= ptr_nxt;
      idx    <= idx_nxt;
      dlat   <= dlat_nxt;
      gnt_q  <= gnt_nxt;
      done_q <= done_nxt;
      s_q    <= s_nxt;
      r_q    <= r_nxt;
      busy_q <= busy_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.r    = r_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_sr_register_write_arbiter.sv
// Bench for sr_register_write_arbiter: SR register model on the s/r lines,
// transaction-level reference model, directed scenarios plus random traffic.
// Honours READBACK_VERIFY_EN for the expected err value.
module tb_sr_register_write_arbiter;
  import sr_ctrl_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
`ifdef READBACK_VERIFY_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sr_register_write_arbiter_if #(.N(N), .W(W)) bus ();

  sr_register_write_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The shared SR register itself: untouched by reset.
  logic [W-1:0] reg_q     = '0;
  logic [W-1:0] force_val = '0;
  logic         force_en  = 1'b0;

  always @(posedge clk) begin
    for (int b = 0; b < int'(W); b++) begin
      if (bus.s[b] && !bus.r[b])      reg_q[b] <= 1'b1;
      else if (!bus.s[b] && bus.r[b]) reg_q[b] <= 1'b0;
      else if (bus.s[b] && bus.r[b])  reg_q[b] <= 1'bx;
    end
  end

  assign bus.q = force_en ? force_val : reg_q;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each write is a transaction whose visible outputs are
  // fixed by its age in edges since the grant (0 grant, 1 s/r, 2 q valid,
  // 3 done); a new grant is taken at age 4 or whenever no write is active.
  bit           m_tx  = 1'b0;
  int           m_age = 0;
  int unsigned  m_i   = 0;
  int unsigned  m_ptr = 0;
  logic [W-1:0] m_d   = '0;
  logic [W-1:0] q_now;
  logic [N-1:0] e_gnt  = '0;
  logic [N-1:0] e_done = '0;
  logic [W-1:0] e_s    = '0;
  logic [W-1:0] e_r    = '0;
  logic         e_busy = 1'b0;
  logic         e_err  = 1'b0;
  logic         e_qv   = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_tx = 1'b0; m_ptr = 0;
      e_gnt = '0; e_done = '0; e_s = '0; e_r = '0;
      e_busy = 1'b0; e_err = 1'b0; e_qv = 1'b0;
    end else begin
      q_now = bus.q;
      if (m_tx) begin
        m_age++;
        if (m_age == 4) m_tx = 1'b0;
      end
      if (!m_tx && bus.req != '0) begin
        for (int unsigned k = 0; k < N; k++) begin
          int unsigned j;
          j = (m_ptr + k) % N;
          if (!m_tx && ((bus.req >> j) & N'(1)) != '0) begin
            m_tx  = 1'b1;
            m_i   = j;
            m_age = 0;
            m_d   = W'(bus.wdata >> (j * W));
          end
        end
      end
      e_gnt  = m_tx ? (N'(1) << m_i) : '0;
      e_busy = m_tx && (m_age < 3);
      e_s    = (m_tx && m_age == 1) ? m_d : '0;
      e_r    = (m_tx && m_age == 1) ? ~m_d : '0;
      e_done = (m_tx && m_age == 3) ? (N'(1) << m_i) : '0;
      e_err  = 1'b0;
      if (m_tx && m_age == 3) begin
`ifdef READBACK_VERIFY_EN
        e_err = (q_now !== m_d);
`endif
        m_ptr = (m_i + 1) % N;
      end
      e_qv = m_tx && (m_age == 2 || m_age == 3) && !force_en;
    end
  end

  // Per-cycle comparison against the model, plus a log of completions.
  int cyc = 0;
  int done_log[$];
  int done_cyc[$];

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (rst_n) begin
      chk("gnt",  64'(bus.gnt),  64'(e_gnt));
      chk("done", 64'(bus.done), 64'(e_done));
      chk("s",    64'(bus.s),    64'(e_s));
      chk("r",    64'(bus.r),    64'(e_r));
      chk("busy", 64'(bus.busy), 64'(e_busy));
      chk("err",  64'(bus.err),  64'(e_err));
      chk("s_and_r", 64'(bus.s & bus.r), 64'(0));
      chk("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'(1));
      if (e_qv) chk("q", 64'(bus.q), 64'(m_d));
      for (int b = 0; b < int'(N); b++) begin
        if (bus.done[b]) begin
          done_log.push_back(b);
          done_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] v);
    logic [N*W-1:0] m;
    m = {{(N*W-W){1'b0}}, {W{1'b1}}} << (i * int'(W));
    bus.wdata = (bus.wdata & ~m) | ((N*W)'(v) << (i * int'(W)));
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  int order2[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req   = '0;
    bus.wdata = '0;
    step(2);
    chk("rst_gnt",  64'(bus.gnt),  64'(0));
    chk("rst_s",    64'(bus.s),    64'(0));
    chk("rst_r",    64'(bus.r),    64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_err",  64'(bus.err),  64'(0));
    rst_n = 1'b1;
    step(1);

    // Single write from requester 0.
    set_lane(0, 8'hA5);
    bus.req = 4'b0001;
    step(1);
    chk("t1_gnt",  64'(bus.gnt),  64'(4'b0001));
    chk("t1_busy", 64'(bus.busy), 64'(1));
    step(1);
    chk("t1_s", 64'(bus.s), 64'(8'hA5));
    chk("t1_r", 64'(bus.r), 64'(8'h5A));
    step(1);
    chk("t1_q", 64'(bus.q), 64'(8'hA5));
    chk("t1_s_hold", 64'(bus.s), 64'(0));
    step(1);
    chk("t1_done", 64'(bus.done), 64'(4'b0001));
    chk("t1_err",  64'(bus.err),  64'(0));
    bus.req = '0;
    step(2);

    // All four requesting: round-robin from pointer 0, 4 cycles apart.
    do_reset();
    set_lane(0, 8'h11); set_lane(1, 8'h22); set_lane(2, 8'h33); set_lane(3, 8'h44);
    done_log.delete(); done_cyc.delete();
    bus.req = 4'b1111;
    step(20);
    bus.req = '0;
    chk("t2_count", 64'(done_log.size()), 64'(5));
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", 64'((i < done_log.size()) ? done_log[i] : -1), 64'(order2[i]));
    end
    for (int i = 1; i < 5; i++) begin
      chk("t2_spacing", 64'((i < done_cyc.size()) ? done_cyc[i] - done_cyc[i-1] : -1), 64'(4));
    end
    chk("t2_q_last", 64'(bus.q), 64'(8'h11));
    step(2);

    // Pointer moved to 2 by a write from requester 1; 0 and 1 then alternate.
    set_lane(1, 8'h5C);
    bus.req = 4'b0010;
    step(4);
    bus.req = 4'b0011;
    done_log.delete();
    step(8);
    bus.req = '0;
    chk("t3_count", 64'(done_log.size()), 64'(2));
    chk("t3_first",  64'((done_log.size() > 0) ? done_log[0] : -1), 64'(0));
    chk("t3_second", 64'((done_log.size() > 1) ? done_log[1] : -1), 64'(1));
    step(2);

    // Reset during DRIVE: abort, register keeps 00, pointer back to 0.
    do_reset();
    set_lane(2, 8'h00);
    bus.req = 4'b0100;
    step(4);
    bus.req = '0;
    step(2);
    chk("t4_q_pre", 64'(bus.q), 64'(8'h00));
    set_lane(0, 8'hFF);
    bus.req = 4'b0001;
    step(1);
    chk("t4_gnt_pre", 64'(bus.gnt), 64'(4'b0001));
    rst_n = 1'b0;
    #1;
    chk("t4_gnt",  64'(bus.gnt),  64'(0));
    chk("t4_s",    64'(bus.s),    64'(0));
    chk("t4_r",    64'(bus.r),    64'(0));
    chk("t4_busy", 64'(bus.busy), 64'(0));
    chk("t4_done", 64'(bus.done), 64'(0));
    bus.req = '0;
    step(3);
    chk("t4_q_kept",  64'(bus.q),    64'(8'h00));
    chk("t4_no_done", 64'(bus.done), 64'(0));
    rst_n = 1'b1;
    set_lane(1, 8'h66); set_lane(3, 8'h99);
    bus.req = 4'b1010;
    step(1);
    chk("t4_restart_gnt", 64'(bus.gnt), 64'(4'b0010));
    step(3);
    chk("t4_restart_done", 64'(bus.done), 64'(4'b0010));
    chk("t4_restart_q",    64'(reg_q),    64'(8'h66));
    bus.req = '0;
    step(2);

    // Readback forced to 00 while writing 0F.
    force_val = 8'h00;
    force_en  = 1'b1;
    set_lane(0, 8'h0F);
    bus.req = 4'b0001;
    step(4);
    chk("t6_done", 64'(bus.done), 64'(4'b0001));
    chk("t6_err",  64'(bus.err),  64'(EXP_ERR));
    bus.req  = '0;
    force_en = 1'b0;
    step(2);

    // Random traffic: request changes, drops and data churn after grant.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) bus.wdata = (N*W)'($urandom);
      step(1);
    end
    bus.req = '0;
    step(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
